// File: rtl/huff_bit_unpacker_if.sv
// Stream/decoder handshake bundle for huff_bit_unpacker.
// Carries the err flag only when HUFF_UNPACK_ERR_EN is defined.
interface huff_bit_unpacker_if #(
  parameter int BUS_WIDTH    = 64,
  parameter int MAX_CODE_LEN = 16
);
  localparam int LW = $clog2(MAX_CODE_LEN + 1);
  localparam int CW = $clog2(2*BUS_WIDTH + 1);

  logic [BUS_WIDTH-1:0]    din;
  logic                    we;
  logic                    busy;
  logic [MAX_CODE_LEN-1:0] win;
  logic                    win_valid;
  logic                    consume;
  logic [LW-1:0]           consume_len;
  logic                    flush;
  logic [CW-1:0]           bit_cnt;
`ifdef HUFF_UNPACK_ERR_EN
  logic                    err;

  modport master (
    output din, we, consume, consume_len, flush,
    input  busy, win, win_valid, bit_cnt, err
  );
  modport slave (
    input  din, we, consume, consume_len, flush,
    output busy, win, win_valid, bit_cnt, err
  );
`else
  modport master (
    output din, we, consume, consume_len, flush,
    input  busy, win, win_valid, bit_cnt
  );
  modport slave (
    input  din, we, consume, consume_len, flush,
    output busy, win, win_valid, bit_cnt
  );
`endif
endinterface

// File: rtl/huff_bit_unpacker.sv
// Huffman decode-side bit unpacker: buffers packed words, exposes an MSB-first lookahead
// window and retires matched code lengths. Define HUFF_UNPACK_ERR_EN for a sticky err output.
module huff_bit_unpacker #(
  parameter int BUS_WIDTH    = 64,
  parameter int MAX_CODE_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  huff_bit_unpacker_if.slave bus
);
  localparam int LW    = $clog2(MAX_CODE_LEN + 1);
  localparam int CW    = $clog2(2*BUS_WIDTH + 1);
  localparam int BUF_W = 2*BUS_WIDTH;
  localparam logic [CW-1:0] BW_C = CW'(BUS_WIDTH);
  localparam logic [CW-1:0] ML_C = CW'(MAX_CODE_LEN);
  localparam logic [LW-1:0] ML_L = LW'(MAX_CODE_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [BUF_W-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             busy, win_valid;
  logic             wr_ok, cons_ok;
  logic [LW-1:0]    len_clamp;
  logic [CW-1:0]    n, cnt_c;
  logic [BUF_W-1:0] data_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Consume first, then append the new word directly below the surviving bits.
  always_comb begin
    wr_ok     = bus.we && !busy;
    cons_ok   = bus.consume && win_valid;
    len_clamp = (bus.consume_len > ML_L) ? ML_L : bus.consume_len;
    n         = '0;
    if (cons_ok)
      n = (CW'(len_clamp) > cnt_q) ? cnt_q : CW'(len_clamp);
    cnt_c  = cnt_q - n;
    data_c = data_q << n;
    data_d = data_c;
    cnt_d  = cnt_c;
    if (wr_ok) begin
      data_d = data_c | ({bus.din, {BUS_WIDTH{1'b0}}} >> cnt_c);
      cnt_d  = cnt_c + BW_C;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (wr_ok) state_d = RUN;
      RUN: begin
        if (cnt_d == '0)    state_d = IDLE;
        else if (bus.flush) state_d = DRAIN;
      end
      DRAIN: if (cnt_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (cnt_q > BW_C) || (state_q == DRAIN);
    win_valid = (state_q == DRAIN) ? (cnt_q != '0) : (cnt_q >= ML_C);
  end

  assign bus.busy      = busy;
  assign bus.win_valid = win_valid;
  assign bus.win       = data_q[BUF_W-1 -: MAX_CODE_LEN];
  assign bus.bit_cnt   = cnt_q;

`ifdef HUFF_UNPACK_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (bus.we & busy)
          | (bus.consume & (!win_valid
                            | (CW'(bus.consume_len) > cnt_q)
                            | (bus.consume_len > ML_L)));
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_huff_bit_unpacker.sv
// Self-checking bench for huff_bit_unpacker: directed scenarios plus randomized traffic
// checked against a bit-queue reference model.
module tb_huff_bit_unpacker;
  localparam int BW = 64;
  localparam int ML = 16;
  localparam int LW = $clog2(ML + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  huff_bit_unpacker_if #(.BUS_WIDTH(BW), .MAX_CODE_LEN(ML)) bus ();
  huff_bit_unpacker #(.BUS_WIDTH(BW), .MAX_CODE_LEN(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: the stream as a queue of bits, oldest first.
  bit mq[$];
  bit m_drain;
  bit m_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ML-1:0] m_win();
    logic [ML-1:0] w;
    w = '0;
    for (int i = 0; i < ML; i++)
      if (i < mq.size()) w[ML-1-i] = mq[i];
    return w;
  endfunction

  function automatic bit m_busy();
    return (mq.size() > BW) || m_drain;
  endfunction

  function automatic bit m_valid();
    return m_drain ? (mq.size() > 0) : (mq.size() >= ML);
  endfunction

  task automatic compare_all();
    check("win",       64'(bus.win),       64'(m_win()));
    check("win_valid", 64'(bus.win_valid), 64'(m_valid()));
    check("bit_cnt",   64'(bus.bit_cnt),   64'(mq.size()));
    check("busy",      64'(bus.busy),      64'(m_busy()));
`ifdef HUFF_UNPACK_ERR_EN
    check("err",       64'(bus.err),       64'(m_err));
`endif
  endtask

  task automatic idle_inputs();
    bus.we = 1'b0; bus.din = '0; bus.consume = 1'b0; bus.consume_len = '0; bus.flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    mq.delete();
    m_drain = 1'b0;
    m_err   = 1'b0;
    rst     = 1'b0;
    compare_all();
  endtask

  task automatic step(input bit we, input logic [BW-1:0] din, input bit cons,
                      input int len, input bit fl);
    bit busy0, valid0, idle0;
    int sz0, n;
    busy0  = m_busy();
    valid0 = m_valid();
    idle0  = (mq.size() == 0) && !m_drain;
    sz0    = mq.size();
    bus.we = we; bus.din = din; bus.consume = cons; bus.consume_len = LW'(len); bus.flush = fl;
    @(posedge clk);
    if (cons && valid0) begin
      n = (len > ML) ? ML : len;
      if (n > mq.size()) n = mq.size();
      repeat (n) void'(mq.pop_front());
    end
    if (we && !busy0)
      for (int i = BW-1; i >= 0; i--) mq.push_back(din[i]);
    if ((we && busy0) || (cons && (!valid0 || len > sz0 || len > ML))) m_err = 1'b1;
    if (m_drain) begin
      if (mq.size() == 0) m_drain = 1'b0;
    end else if (fl && !idle0) begin
      m_drain = (mq.size() > 0);
    end
    #1;
    idle_inputs();
    compare_all();
  endtask

  // Leaves exactly ten known bits (1011001110) buffered in the run state.
  task automatic drain_setup();
    logic [BW-1:0] w;
    do_reset();
    w = {$urandom, $urandom};
    w[9:0] = 10'b1011001110;
    step(1, w, 0, 0, 0);
    repeat (3) step(0, '0, 1, 16, 0);
    step(0, '0, 1, 6, 0);
    check("drain_pre_cnt",   64'(bus.bit_cnt),   64'd10);
    check("drain_pre_valid", 64'(bus.win_valid), 64'd0);
  endtask

  initial begin
    logic [BW-1:0] w1, w2;
    int len;
    rst = 1'b1;
    idle_inputs();

    // Reset state
    do_reset();
    check("rst_cnt",   64'(bus.bit_cnt),   64'd0);
    check("rst_win",   64'(bus.win),       64'd0);
    check("rst_valid", 64'(bus.win_valid), 64'd0);
    check("rst_busy",  64'(bus.busy),      64'd0);

    // Single write then short consume
    step(1, 64'hF000_0000_0000_0000, 0, 0, 0);
    check("single_win",   64'(bus.win),       64'hF000);
    check("single_valid", 64'(bus.win_valid), 64'd1);
    check("single_cnt",   64'(bus.bit_cnt),   64'd64);
    check("single_busy",  64'(bus.busy),      64'd0);
    step(0, '0, 1, 4, 0);
    check("cons4_win", 64'(bus.win),     64'h0000);
    check("cons4_cnt", 64'(bus.bit_cnt), 64'd60);

    // Fill and overflow
    do_reset();
    repeat (3) step(1, {$urandom, $urandom}, 0, 0, 0);
    check("ovf_cnt",  64'(bus.bit_cnt), 64'd128);
    check("ovf_busy", 64'(bus.busy),    64'd1);
`ifdef HUFF_UNPACK_ERR_EN
    check("ovf_err",  64'(bus.err),     64'd1);
`endif

    // Simultaneous write and consume
    do_reset();
    w1 = {$urandom, $urandom};
    w2 = {$urandom, $urandom};
    step(1, w1, 0, 0, 0);
    step(1, w2, 1, 5, 0);
    check("simul_cnt", 64'(bus.bit_cnt), 64'd123);
    check("simul_win", 64'(bus.win),     64'(w1[58:43]));

    // Drain with an exact consume
    drain_setup();
    step(0, '0, 0, 0, 1);
    check("drain_valid", 64'(bus.win_valid), 64'd1);
    check("drain_win",   64'(bus.win),       64'hB380);
    check("drain_busy",  64'(bus.busy),      64'd1);
    step(0, '0, 1, 10, 0);
    check("drain_end_cnt",   64'(bus.bit_cnt),   64'd0);
    check("drain_end_valid", 64'(bus.win_valid), 64'd0);
    check("drain_end_busy",  64'(bus.busy),      64'd0);
    step(1, {$urandom, $urandom}, 0, 0, 0);
    check("drain_reaccept", 64'(bus.bit_cnt), 64'd64);

    // Over-consume while draining
    drain_setup();
`ifdef HUFF_UNPACK_ERR_EN
    check("oc_err_pre", 64'(bus.err), 64'd0);
`endif
    step(0, '0, 0, 0, 1);
    step(0, '0, 1, 12, 0);
    check("oc_cnt",   64'(bus.bit_cnt),   64'd0);
    check("oc_valid", 64'(bus.win_valid), 64'd0);
    check("oc_busy",  64'(bus.busy),      64'd0);
`ifdef HUFF_UNPACK_ERR_EN
    check("oc_err",   64'(bus.err),       64'd1);
`endif

    // Randomized traffic, with periodic mid-stream resets
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 1000 == 999) begin
        do_reset();
      end else begin
        len = int'($urandom_range(0, 20));
        step(($urandom_range(0, 2) == 0), {$urandom, $urandom},
             ($urandom_range(0, 3) != 0), len, ($urandom_range(0, 49) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/huff_bit_unpacker.md
# huff_bit_unpacker

Bit-stream unpacker on the Huffman decode side. It accepts the packed BUS_WIDTH-bit words produced by the encode path and buffers them. It presents an MSB-first window of the next MAX_CODE_LEN stream bits to the symbol decoder. The decoder returns the length of the code it matched, and the block retires that many bits.

## Interface
- BUS_WIDTH, 64, width of packed input word; must be ≥ MAX_CODE_LEN.
- MAX_CODE_LEN, 16, longest Huffman code; width of the lookahead window.
- LW (local), $clog2(MAX_CODE_LEN+1), width of consume_len.
- CW (local), $clog2(2*BUS_WIDTH+1), width of bit_cnt.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  BUS_WIDTH  packed stream word; din[BUS_WIDTH-1] is the earliest bit.
- we  in  1  write strobe for din; accepted only when busy=0.
- busy  out  1  cannot accept a word this cycle.
- win  out  MAX_CODE_LEN  next stream bits; win[MAX_CODE_LEN-1] is the oldest bit; zero-padded past bit_cnt.
- win_valid  out  1  win holds enough bits to decode.
- consume  in  1  retire consume_len bits; ignored when win_valid=0.
- consume_len  in  LW  bits to retire; 0 = no-op; values > MAX_CODE_LEN are clamped to MAX_CODE_LEN.
- flush  in  1  end of stream; drain the remaining bits with a short window.
- bit_cnt  out  CW  valid bits currently buffered.

## Operation
- Storage: 2*BUS_WIDTH-bit register buf, left-aligned; the oldest valid bit is at buf[2*BUS_WIDTH-1]. Counter cnt is output as bit_cnt.
- Consume: buf shifts left by n = min(consume_len, cnt), with zero fill; cnt -= n.
- Write: din is placed directly below the remaining valid bits, after any same-cycle consume; cnt += BUS_WIDTH.
- Simultaneous we and consume: both apply in one cycle; new cnt = cnt − n + BUS_WIDTH.
- busy = (cnt > BUS_WIDTH) or state==DRAIN.
- A we while busy drops the word; buf and cnt are unchanged.
- The FSM has three states:
  - IDLE: cnt==0. we moves to RUN. flush stays in IDLE.
  - RUN: win_valid = (cnt ≥ MAX_CODE_LEN). flush moves to DRAIN; a we in the same cycle as flush is still accepted if busy=0.
  - DRAIN: win_valid = (cnt > 0). When cnt reaches 0 after a consume, the state moves to IDLE. we is ignored.
- In DRAIN, a consume_len larger than cnt clears cnt to 0.
- win is a combinational slice of the registered buf: buf[2*BUS_WIDTH-1 -: MAX_CODE_LEN]. Bits past cnt read as 0, guaranteed by zero-fill on shift.
- Reset drives buf=0, cnt=0, state=IDLE, win=0, win_valid=0, busy=0, bit_cnt=0, err=0. Reset mid-stream discards all buffered bits.

## Timing
- Write latency: a word written at edge k is reflected in win, win_valid and bit_cnt after edge k.
- Consume latency: a consume at edge k shows the new window after edge k. Back-to-back consumes every cycle are supported.
- busy is derived from registered state only. It has no combinational path from we, consume or flush.
- Sustained throughput is one BUS_WIDTH word every ⌈BUS_WIDTH/avg_len⌉ cycles, limited only by consume.

## Configuration
- HUFF_UNPACK_ERR_EN defined: adds output err (1 bit, reset 0), sticky until rst. err sets on:
  - we while busy=1;
  - consume while win_valid=0;
  - consume_len > cnt;
  - consume_len > MAX_CODE_LEN.
- HUFF_UNPACK_ERR_EN undefined: no err port. The same conditions are silently ignored or clamped as described above.

## Test plan
- Reset: hold rst 2 cycles. All outputs are 0 and bit_cnt=0.
- Single write: din=64'hF000_0000_0000_0000 with we. The next cycle shows win=16'hF000, win_valid=1, bit_cnt=64, busy=0. Then consume len 4: win=16'h0000, bit_cnt=60.
- Fill and overflow: three consecutive we.
  - Word 2 is accepted, giving bit_cnt=128 and busy=1.
  - Word 3 is dropped and bit_cnt stays 128.
  - err=1 with HUFF_UNPACK_ERR_EN.
- Simultaneous write and consume: at bit_cnt=64, we plus consume len 5. The next cycle shows bit_cnt=123, and win shows bits 5..20 of word 1.
- Drain:
  - At 10 bits left (1011001110), assert flush. Expect win_valid=1 and win=16'b1011001110_000000.
  - Consume 10. Expect bit_cnt=0, IDLE, win_valid=0, busy=0.
- Over-consume in DRAIN: 10 bits left, consume 12. bit_cnt=0 and the state returns to IDLE; err=1 only with the macro defined.
